// File: rtl/packet_switch_rx_avmm_rsp_agg.sv
// Read-response aggregator for the RX_0 / RX_1 debug register regions.
// Every accepted host read leaves a tag in an in-order FIFO. Each region's
// read data is buffered in a per-region FIFO, or forwarded straight through
// when it answers the head read. Responses go back to the host in request
// order. Unmapped reads get MISS_DATA. A head read that is never answered
// gets TIMEOUT_DATA, and the late answer to it is dropped when it arrives.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   avmm_address/read/write        host request side (writes are posted, not tracked)
//   avmm_waitrequest               high while the tag FIFO is full
//   avmm_readdata/readdatavalid    registered in-order read responses
//   rsp_readdata_r/readdatavalid_r region r read responses (r = 0, 1)
//   err_clr                        clears the sticky error flags
//   err_timeout, err_unexpected    sticky error flags
module packet_switch_rx_avmm_rsp_agg #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 32,
    parameter logic [ADDR_WIDTH-1:0] RX0_LO = 'h8258,
    parameter logic [ADDR_WIDTH-1:0] RX0_HI = 'h8294,
    parameter logic [ADDR_WIDTH-1:0] RX1_LO = 'h8298,
    parameter logic [ADDR_WIDTH-1:0] RX1_HI = 'h82D4,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 64,
    parameter logic [DATA_WIDTH-1:0] MISS_DATA    = 'hBADC0DE0,
    parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] avmm_address,
    input  logic                  avmm_read,
    input  logic                  avmm_write,
    output logic                  avmm_waitrequest,
    output logic [DATA_WIDTH-1:0] avmm_readdata,
    output logic                  avmm_readdatavalid,
    input  logic [DATA_WIDTH-1:0] rsp_readdata_0,
    input  logic                  rsp_readdatavalid_0,
    input  logic [DATA_WIDTH-1:0] rsp_readdata_1,
    input  logic                  rsp_readdatavalid_1,
    input  logic                  err_clr,
    output logic                  err_timeout,
    output logic                  err_unexpected
);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {TAG_RX0 = 2'd0, TAG_RX1 = 2'd1, TAG_MISS = 2'd2} tag_t;

    tag_t                  tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      tag_wp, tag_rp;
    logic [CNT_W-1:0]      tag_cnt;
    logic [DATA_WIDTH-1:0] rf_mem [2][MAX_OUTSTANDING];
    logic [PTR_W-1:0]      rf_wp [2];
    logic [PTR_W-1:0]      rf_rp [2];
    logic [CNT_W-1:0]      rf_cnt [2];
    logic [CNT_W-1:0]      pend_cnt [2];
    logic [CNT_W-1:0]      drop_cnt [2];
    logic [CNT_W-1:0]      pend_nxt [2];
    logic [CNT_W-1:0]      drop_nxt [2];
    logic [TO_W-1:0]       to_cnt;

    logic                  accept;
    tag_t                  new_tag;
    tag_t                  head;
    logic                  head_r;
    logic [DATA_WIDTH-1:0] rsp_data [2];
    logic [1:0]            rsp_valid, rsp_acc, rsp_drop, rsp_unexp;
    logic [1:0]            rf_push, rf_pop, bypass, tmo;
    logic                  pop;
    logic [DATA_WIDTH-1:0] pop_data;

    assign avmm_waitrequest = (tag_cnt == CNT_FULL);
    assign accept           = avmm_read && !avmm_waitrequest;
    assign rsp_data[0]      = rsp_readdata_0;
    assign rsp_data[1]      = rsp_readdata_1;
    assign rsp_valid        = {rsp_readdatavalid_1, rsp_readdatavalid_0};
    assign head             = tag_mem[tag_rp];
    assign head_r           = (head == TAG_RX1);

    always_comb begin
        new_tag = TAG_MISS;
        if (avmm_address >= RX0_LO && avmm_address <= RX0_HI)
            new_tag = TAG_RX0;
        else if (avmm_address >= RX1_LO && avmm_address <= RX1_HI)
            new_tag = TAG_RX1;
    end

    always_comb begin
        rsp_acc   = '0;
        rsp_drop  = '0;
        rsp_unexp = '0;
        for (int r = 0; r < 2; r++) begin
            if (rsp_valid[r]) begin
                if (drop_cnt[r] != '0)      rsp_drop[r]  = 1'b1;
                else if (pend_cnt[r] != '0) rsp_acc[r]   = 1'b1;
                else                        rsp_unexp[r] = 1'b1;
            end
        end
    end

    // Head pop priority: miss, buffered data, bypass, timeout. A response
    // arriving with the timeout for the same head therefore wins.
    always_comb begin
        pop      = 1'b0;
        pop_data = '0;
        rf_pop   = '0;
        bypass   = '0;
        tmo      = '0;
        if (tag_cnt != '0) begin
            if (head == TAG_MISS) begin
                pop      = 1'b1;
                pop_data = MISS_DATA;
            end else if (rf_cnt[head_r] != '0) begin
                pop            = 1'b1;
                rf_pop[head_r] = 1'b1;
                pop_data       = rf_mem[head_r][rf_rp[head_r]];
            end else if (rsp_acc[head_r]) begin
                pop            = 1'b1;
                bypass[head_r] = 1'b1;
                pop_data       = rsp_data[head_r];
            end else if (to_cnt == TO_LAST) begin
                pop         = 1'b1;
                tmo[head_r] = 1'b1;
                pop_data    = TIMEOUT_DATA;
            end
        end
    end

    always_comb begin
        for (int r = 0; r < 2; r++) begin
            rf_push[r]  = rsp_acc[r] && !bypass[r];
            pend_nxt[r] = pend_cnt[r];
            drop_nxt[r] = drop_cnt[r];
            if (accept && new_tag == tag_t'(r)) pend_nxt[r] = pend_nxt[r] + 1'b1;
            if (rsp_acc[r] || tmo[r])           pend_nxt[r] = pend_nxt[r] - 1'b1;
            if (rsp_drop[r])                    drop_nxt[r] = drop_nxt[r] - 1'b1;
            else if (tmo[r] && drop_cnt[r] != CNT_MAX)
                drop_nxt[r] = drop_nxt[r] + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wp             <= '0;
            tag_rp             <= '0;
            tag_cnt            <= '0;
            to_cnt             <= '0;
            avmm_readdata      <= '0;
            avmm_readdatavalid <= 1'b0;
            err_timeout        <= 1'b0;
            err_unexpected     <= 1'b0;
            for (int r = 0; r < 2; r++) begin
                rf_wp[r]    <= '0;
                rf_rp[r]    <= '0;
                rf_cnt[r]   <= '0;
                pend_cnt[r] <= '0;
                drop_cnt[r] <= '0;
            end
        end else begin
            if (accept) begin
                tag_mem[tag_wp] <= new_tag;
                tag_wp          <= tag_wp + 1'b1;
            end
            if (pop) tag_rp <= tag_rp + 1'b1;
            if (accept && !pop)      tag_cnt <= tag_cnt + 1'b1;
            else if (!accept && pop) tag_cnt <= tag_cnt - 1'b1;

            for (int r = 0; r < 2; r++) begin
                if (rf_push[r]) begin
                    rf_mem[r][rf_wp[r]] <= rsp_data[r];
                    rf_wp[r]            <= rf_wp[r] + 1'b1;
                end
                if (rf_pop[r]) rf_rp[r] <= rf_rp[r] + 1'b1;
                if (rf_push[r] && !rf_pop[r])      rf_cnt[r] <= rf_cnt[r] + 1'b1;
                else if (!rf_push[r] && rf_pop[r]) rf_cnt[r] <= rf_cnt[r] - 1'b1;
                pend_cnt[r] <= pend_nxt[r];
                drop_cnt[r] <= drop_nxt[r];
            end

            if (pop || tag_cnt == '0) to_cnt <= '0;
            else                      to_cnt <= to_cnt + 1'b1;

            avmm_readdatavalid <= pop;
            if (pop) avmm_readdata <= pop_data;

            // Set wins over a same-cycle clear.
            err_timeout    <= (|tmo) || (err_timeout && !err_clr);
            err_unexpected <= (|rsp_unexp) || (err_unexpected && !err_clr);
        end
    end

    // Writes are posted to the region decoders and need no response here.
    logic unused_write;
    assign unused_write = avmm_write;
endmodule

// File: tb/tb_packet_switch_rx_avmm_rsp_agg.sv
module tb_packet_switch_rx_avmm_rsp_agg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] avmm_address = '0;
    logic        avmm_read = 1'b0;
    logic        avmm_write = 1'b0;
    logic        avmm_waitrequest;
    logic [31:0] avmm_readdata;
    logic        avmm_readdatavalid;
    logic [31:0] rsp_readdata_0 = '0;
    logic        rsp_readdatavalid_0 = 1'b0;
    logic [31:0] rsp_readdata_1 = '0;
    logic        rsp_readdatavalid_1 = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_timeout;
    logic        err_unexpected;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];

    packet_switch_rx_avmm_rsp_agg dut (
        .clk(clk), .rst(rst),
        .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
        .avmm_waitrequest(avmm_waitrequest), .avmm_readdata(avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .rsp_readdata_0(rsp_readdata_0), .rsp_readdatavalid_0(rsp_readdatavalid_0),
        .rsp_readdata_1(rsp_readdata_1), .rsp_readdatavalid_1(rsp_readdatavalid_1),
        .err_clr(err_clr), .err_timeout(err_timeout), .err_unexpected(err_unexpected)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every response strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && avmm_readdatavalid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rsp_unexpected_strobe: got data %h, required no response", avmm_readdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (avmm_readdata !== e) begin
                    n_bad++;
                    $display("FAIL rsp_data: got %h, required %h", avmm_readdata, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input bit track);
        int n;
        n = 0;
        avmm_address = a;
        avmm_read    = 1'b1;
        while (avmm_waitrequest && n < 200) begin
            tick(1);
            n++;
        end
        if (n >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_accept: got waitrequest stuck, required acceptance");
        end
        if (track) exp_q.push_back(exp);
        tick(1);
        avmm_read = 1'b0;
    endtask

    task automatic rsp(input int r, input logic [31:0] d);
        if (r == 0) begin rsp_readdata_0 = d; rsp_readdatavalid_0 = 1'b1; end
        else        begin rsp_readdata_1 = d; rsp_readdatavalid_1 = 1'b1; end
        tick(1);
        rsp_readdatavalid_0 = 1'b0;
        rsp_readdatavalid_1 = 1'b0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        #2;
        check("reset_rdv", {31'b0, avmm_readdatavalid}, 32'h0);
        check("reset_rdata", avmm_readdata, 32'h0);
        check("reset_wait", {31'b0, avmm_waitrequest}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Posted write: no response expected.
        avmm_address = 16'h8258; avmm_write = 1'b1;
        tick(1);
        avmm_write = 1'b0;
        tick(3);

        // Single RX_0 read, answered three cycles later.
        do_read(16'h8258, 32'h11111111, 1'b1);
        tick(2);
        rsp(0, 32'h11111111);
        check("rx0_rdv_latency", {31'b0, avmm_readdatavalid}, 32'h1);
        check("rx0_data_direct", avmm_readdata, 32'h11111111);
        tick(1);
        check("rx0_rdv_one_cycle", {31'b0, avmm_readdatavalid}, 32'h0);
        check("rx0_no_err", {30'b0, err_timeout, err_unexpected}, 32'h0);

        // Out-of-order region answers returned in request order.
        do_read(16'h8258, 32'h0000000A, 1'b1);
        do_read(16'h82D4, 32'h0000000B, 1'b1);
        rsp(1, 32'h0000000B);
        check("order_b_held", {31'b0, avmm_readdatavalid}, 32'h0);
        rsp(0, 32'h0000000A);
        check("order_a_first", avmm_readdata, 32'h0000000A);
        tick(1);
        check("order_b_second", avmm_readdata, 32'h0000000B);
        tick(2);

        // Unmapped read: data at edge t+2.
        do_read(16'h0100, 32'hBADC0DE0, 1'b1);
        check("miss_not_early", {31'b0, avmm_readdatavalid}, 32'h0);
        tick(1);
        check("miss_rdv", {31'b0, avmm_readdatavalid}, 32'h1);
        check("miss_data", avmm_readdata, 32'hBADC0DE0);
        tick(2);

        // Timeout on RX_1, late answer dropped, next read delivered.
        do_read(16'h8298, 32'hDEADBEEF, 1'b1);
        tick(63);
        check("tmo_not_early", {31'b0, avmm_readdatavalid}, 32'h0);
        tick(1);
        check("tmo_rdv", {31'b0, avmm_readdatavalid}, 32'h1);
        check("tmo_err", {31'b0, err_timeout}, 32'h1);
        tick(2);
        rsp(1, 32'h0000000C);
        check("late_dropped_no_unexp", {31'b0, err_unexpected}, 32'h0);
        tick(2);
        do_read(16'h8298, 32'h0000000D, 1'b1);
        tick(2);
        rsp(1, 32'h0000000D);
        check("after_drop_data", avmm_readdata, 32'h0000000D);
        check("tmo_sticky", {31'b0, err_timeout}, 32'h1);
        clear_errs();
        check("tmo_cleared", {31'b0, err_timeout}, 32'h0);
        tick(2);

        // Fill the tag FIFO, then free one slot with a bypassed answer.
        for (int i = 1; i <= 4; i++) do_read(16'h8258, 32'hE0 + i, 1'b1);
        check("full_wait", {31'b0, avmm_waitrequest}, 32'h1);
        exp_q.push_back(32'hE5);
        avmm_address = 16'h8258; avmm_read = 1'b1;
        rsp_readdata_0 = 32'hE1; rsp_readdatavalid_0 = 1'b1;
        tick(1);
        rsp_readdatavalid_0 = 1'b0;
        check("full_pop_rdv", {31'b0, avmm_readdatavalid}, 32'h1);
        check("full_wait_released", {31'b0, avmm_waitrequest}, 32'h0);
        tick(1);
        avmm_read = 1'b0;
        check("fifth_accepted_full", {31'b0, avmm_waitrequest}, 32'h1);
        for (int i = 2; i <= 5; i++) rsp(0, 32'hE0 + i);
        tick(3);

        // Unsolicited response.
        rsp(1, 32'h12345678);
        check("unexp_err", {31'b0, err_unexpected}, 32'h1);
        clear_errs();
        check("unexp_cleared", {31'b0, err_unexpected}, 32'h0);

        // Reset with two reads in flight.
        do_read(16'h8258, 32'h0, 1'b0);
        do_read(16'h8260, 32'h0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_rdv", {31'b0, avmm_readdatavalid}, 32'h0);
        check("rst_rdata", avmm_readdata, 32'h0);
        check("rst_wait", {31'b0, avmm_waitrequest}, 32'h0);
        tick(2);
        rst = 1'b0;
        tick(1);
        rsp(0, 32'h55555555);
        check("post_rst_unexp", {31'b0, err_unexpected}, 32'h1);
        tick(4);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/packet_switch_rx_avmm_rsp_agg.md
Name: packet_switch_rx_avmm_rsp_agg

Overview:
- Read-response side of the packet switch debug AVMM path for the two RX register regions (RX_0, RX_1).
- Sits between the host AVMM agent and the RX region decoders. It tracks every accepted host read in order, collects each region's readdata/readdatavalid, and returns responses to the host in request order.
- Reads to unmapped addresses get a miss response. Reads whose region never answers get a timeout response.

Parameters:
ADDR_WIDTH, 16, host address width
DATA_WIDTH, 32, data width
RX0_LO, 'h8258, RX_0 first word address (inclusive)
RX0_HI, 'h8294, RX_0 last word address (inclusive)
RX1_LO, 'h8298, RX_1 first word address (inclusive)
RX1_HI, 'h82D4, RX_1 last word address (inclusive)
MAX_OUTSTANDING, 4, depth of the tag FIFO and of each region response FIFO (power of 2, >=2)
TIMEOUT_CYCLES, 64, cycles a head read waits before it is answered with a timeout
MISS_DATA, 'hBADC0DE0, readdata returned for an unmapped read
TIMEOUT_DATA, 'hDEADBEEF, readdata returned for a timed-out read

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
avmm_address  in  ADDR_WIDTH  host address
avmm_read  in  1  host read strobe
avmm_write  in  1  host write strobe (posted, not tracked)
avmm_waitrequest  out  1  high when the tag FIFO is full
avmm_readdata  out  DATA_WIDTH  response data
avmm_readdatavalid  out  1  response strobe
rsp_readdata_0  in  DATA_WIDTH  RX_0 read data
rsp_readdatavalid_0  in  1  RX_0 data strobe
rsp_readdata_1  in  DATA_WIDTH  RX_1 read data
rsp_readdatavalid_1  in  1  RX_1 data strobe
err_clr  in  1  clears all sticky error flags
err_timeout  out  1  sticky: a read timed out
err_unexpected  out  1  sticky: an unsolicited response was discarded

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0.
  - Tag FIFO and both region FIFOs are emptied.
  - pend_cnt[r], drop_cnt[r] and the timeout counter are cleared.
- avmm_waitrequest is combinational and equals (tag count == MAX_OUTSTANDING).
- A read is accepted when avmm_read && !avmm_waitrequest.
- Writes are ignored by this block; waitrequest still applies to them.
- On acceptance, a tag {RX0, RX1, MISS} is pushed, decoded from the inclusive address ranges. For RX0/RX1 tags, pend_cnt[r] increments.
- Region response handling, evaluated each cycle with rsp_readdatavalid_r high:
  - If drop_cnt[r] > 0: discard the response and decrement drop_cnt[r] (late response to a timed-out read).
  - Else if pend_cnt[r] > 0: accept it and decrement pend_cnt[r]. It is either consumed directly by a same-cycle head pop (bypass, only when region FIFO r is empty) or pushed into region FIFO r.
  - Else: discard and set err_unexpected.
- Head pop: at most one per cycle, using the tag FIFO head in priority order:
  1. MISS: pop; data = MISS_DATA.
  2. RX r with region FIFO r non-empty: pop both FIFOs; data = FIFO r head.
  3. RX r with FIFO r empty and rsp_readdatavalid_r accepted this cycle: pop; data = rsp_readdata_r (bypass).
  4. RX r with timeout counter == TIMEOUT_CYCLES-1: pop; data = TIMEOUT_DATA; pend_cnt[r]--, drop_cnt[r]++ (saturating); set err_timeout.
- A response arriving in the same cycle as a timeout for the same head wins: it is returned as normal data and no timeout is taken.
- Output timing: avmm_readdatavalid and avmm_readdata are registered 1 cycle after the pop decision. readdatavalid is high for exactly one cycle per pop. readdata holds its last value otherwise.
- Timeout counter:
  - Cleared on every pop and whenever the tag FIFO is empty.
  - Increments each cycle the head is RX r with no pop.
  - Width is clog2(TIMEOUT_CYCLES).
- Latencies with an empty pipeline:
  - Miss read: accepted at edge t, readdatavalid at edge t+2.
  - Region response: arriving at edge t for the head, readdatavalid at edge t+1.
- Simultaneous push and pop in one cycle is allowed. A full tag FIFO accepts a new read only in the following cycle, since waitrequest does not look ahead.
- err_clr clears the sticky flags. Setting and clearing in the same cycle leaves the flag set.
- Counters are sized clog2(MAX_OUTSTANDING+1) and never wrap.

Test Plan:
- Read 'h8258, RX_0 answers 'h11111111 three cycles later -> one readdatavalid with 'h11111111, one cycle after rsp_readdatavalid_0; no errors.
- Reads to 'h8258 (RX_0) then 'h82D4 (RX_1), with RX_1 answering 'hB before RX_0 answers 'hA -> host sees 'hA then 'hB; RX_1 data buffered in its FIFO.
- Read 'h0100 -> readdatavalid at edge t+2 with 'hBADC0DE0; pend_cnt unchanged.
- Read 'h8298 with no RX_1 answer -> 'hDEADBEEF after 64 cycles, err_timeout=1. A later RX_1 response 'hC is discarded (drop_cnt returns to 0). A following RX_1 read returning 'hD is delivered as 'hD. err_clr -> err_timeout=0.
- Five back-to-back reads with no responses -> waitrequest high after the 4th acceptance. RX_0 answer to head -> readdatavalid, waitrequest low next cycle, 5th read accepted.
- Unsolicited rsp_readdatavalid_1 with nothing pending -> no readdatavalid, err_unexpected=1. Separately, assert rst while 2 reads are pending -> all state cleared, outputs 0, and a post-reset region response sets err_unexpected.
